// File: rtl/inst_pkg.sv
// Shared definitions for the instruction-decode stage: default geometry, field positions and the decoded-fields record.
package inst_pkg;

  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_COND_W  = 2;
  localparam int unsigned DEF_OPC_W   = 4;
  localparam int unsigned DEF_REG_AW  = 3;
  localparam int unsigned DEF_SHIFT_W = 4;

  localparam logic [2**DEF_OPC_W-1:0] DEF_OPC_LEGAL_MASK = 16'h0FFF;

  // Field LSB positions for the default geometry, walking down from the MSB.
  localparam int unsigned DEF_COND_LSB = DEF_INSTR_W - DEF_COND_W;
  localparam int unsigned DEF_OPC_LSB  = DEF_COND_LSB - DEF_OPC_W;
  localparam int unsigned DEF_DEST_LSB = DEF_OPC_LSB - DEF_REG_AW;
  localparam int unsigned DEF_SRC1_LSB = DEF_DEST_LSB - DEF_REG_AW;
  localparam int unsigned DEF_SRC2_LSB = DEF_SRC1_LSB - DEF_REG_AW;

  typedef struct packed {
    logic [DEF_COND_W-1:0]  cond;
    logic [DEF_OPC_W-1:0]   op_code;
    logic [DEF_REG_AW-1:0]  dest;
    logic [DEF_REG_AW-1:0]  src1;
    logic [DEF_REG_AW-1:0]  src2;
    logic [DEF_SHIFT_W-1:0] shift;
    logic                   illegal;
  } dec_fields_t;

endpackage

// File: rtl/dec_skid_buf.sv
// Two-entry valid/ready skid buffer: output register plus one skid entry, strict FIFO, synchronous flush.
module dec_skid_buf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              or_vld;
  logic [DATA_W-1:0] or_data;
  logic              sk_vld;
  logic [DATA_W-1:0] sk_data;
  logic              in_fire;
  logic              out_fire;

  // Ready depends only on stored state, so no combinational path from out_ready.
  assign in_ready  = ~sk_vld;
  assign out_valid = or_vld;
  assign out_data  = or_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = or_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld  <= 1'b0;
      or_data <= '0;
      sk_vld  <= 1'b0;
      sk_data <= '0;
    end else if (flush) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
    end else if (out_fire) begin
      if (sk_vld) begin
        or_data <= sk_data;
        sk_vld  <= 1'b0;
      end else if (in_fire) begin
        or_data <= in_data;
      end else begin
        or_vld <= 1'b0;
      end
    end else if (in_fire) begin
      if (!or_vld) begin
        or_data <= in_data;
        or_vld  <= 1'b1;
      end else begin
        sk_data <= in_data;
        sk_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered instruction-decode stage with skid-buffered handshake and illegal-opcode flag.
// Optional read-after-write hazard tracking is enabled by defining DEC_HAZARD_EN.
module inst_decode_stage
  import inst_pkg::*;
#(
  parameter int unsigned           INSTR_W        = DEF_INSTR_W,
  parameter int unsigned           COND_W         = DEF_COND_W,
  parameter int unsigned           OPC_W          = DEF_OPC_W,
  parameter int unsigned           REG_AW         = DEF_REG_AW,
  parameter int unsigned           SHIFT_W        = DEF_SHIFT_W,
  parameter logic [2**OPC_W-1:0]   OPC_LEGAL_MASK = DEF_OPC_LEGAL_MASK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COND_W-1:0]  cond,
  output logic [OPC_W-1:0]   op_code,
  output logic [REG_AW-1:0]  dest_reg,
  output logic [REG_AW-1:0]  src_reg1,
  output logic [REG_AW-1:0]  src_reg2,
  output logic [SHIFT_W-1:0] shift_bits,
  output logic               illegal,
  output logic               raw_hazard
);

  localparam int unsigned COND_LSB = INSTR_W - COND_W;
  localparam int unsigned OPC_LSB  = COND_LSB - OPC_W;
  localparam int unsigned DEST_LSB = OPC_LSB - REG_AW;
  localparam int unsigned SRC1_LSB = DEST_LSB - REG_AW;
  localparam int unsigned SRC2_LSB = SRC1_LSB - REG_AW;

  logic [INSTR_W-1:0] word;

  dec_skid_buf #(
    .DATA_W (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (word)
  );

  // Fields decode straight from the held output word, so they cannot move during a stall.
  assign cond       = word[COND_LSB +: COND_W];
  assign op_code    = word[OPC_LSB  +: OPC_W];
  assign dest_reg   = word[DEST_LSB +: REG_AW];
  assign src_reg1   = word[SRC1_LSB +: REG_AW];
  assign src_reg2   = word[SRC2_LSB +: REG_AW];
  assign shift_bits = word[SHIFT_W-1:0];
  assign illegal    = out_valid & ~OPC_LEGAL_MASK[op_code];

`ifdef DEC_HAZARD_EN
  logic [REG_AW-1:0] last_dest;
  logic              last_dest_vld;

  // Remember the destination of the most recently issued instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dest     <= '0;
      last_dest_vld <= 1'b0;
    end else if (flush) begin
      last_dest     <= '0;
      last_dest_vld <= 1'b0;
    end else if (out_valid && out_ready) begin
      last_dest     <= dest_reg;
      last_dest_vld <= 1'b1;
    end
  end

  assign raw_hazard = out_valid & last_dest_vld &
                      ((src_reg1 == last_dest) | (src_reg2 == last_dest));
`else
  assign raw_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: vector table plus scoreboard monitor and handshake corner cases.
module tb_inst_decode_stage;
  import inst_pkg::*;

`ifdef DEC_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instr;
  logic [1:0]  cond;
  logic [3:0]  op_code, shift_bits;
  logic [2:0]  dest_reg, src_reg1, src_reg2;
  logic        illegal, raw_hazard;

  always #5 clk = ~clk;

  inst_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .cond(cond), .op_code(op_code), .dest_reg(dest_reg), .src_reg1(src_reg1),
    .src_reg2(src_reg2), .shift_bits(shift_bits), .illegal(illegal), .raw_hazard(raw_hazard)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endfunction

  // Reference decode with fixed bit positions for the 16-bit layout.
  function automatic dec_fields_t model(input logic [15:0] w);
    dec_fields_t r;
    r.cond    = w[15:14];
    r.op_code = w[13:10];
    r.dest    = w[9:7];
    r.src1    = w[6:4];
    r.src2    = w[3:1];
    r.shift   = w[3:0];
    r.illegal = (w[13:10] >= 4'hC);
    return r;
  endfunction

  function automatic dec_fields_t actual();
    dec_fields_t a;
    a = {cond, op_code, dest_reg, src_reg1, src_reg2, shift_bits, illegal};
    return a;
  endfunction

  // Scoreboard monitor: every cycle checks valid/ready occupancy, held fields and hazard flag.
  dec_fields_t sb[$];
  int          out_stamps[$];
  logic [2:0]  m_ld;
  logic        m_ldv;

  always @(negedge clk) begin
    dec_fields_t e;
    logic        exp_h;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      m_ldv = 1'b0;
      m_ld  = 3'd0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      exp_h = 1'b0;
      if (HAZ && out_valid && sb.size() > 0)
        exp_h = m_ldv && (sb[0].src1 == m_ld || sb[0].src2 == m_ld);
      chk("raw_hazard", 32'(raw_hazard), 32'(exp_h));
      if (out_valid && sb.size() > 0) chk("fields", 32'(actual()), 32'(sb[0]));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail_now("extra_output");
        else begin
          e = sb.pop_front();
          out_stamps.push_back(cyc);
          m_ld  = e.dest;
          m_ldv = 1'b1;
        end
      end
      if (flush) begin
        sb.delete();
        m_ldv = 1'b0;
      end else if (in_valid && in_ready) begin
        sb.push_back(model(in_instr));
      end
    end
  end

  // Offer a word and hold it until accepted; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [15:0] w, input bit want_ready);
    int  k;
    bit  r;
    in_instr = w;
    in_valid = 1'b1;
    r = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      r = in_ready;
      if (want_ready) chk("stream_in_ready", 32'(r), 32'd1);
      @(posedge clk);
      #1;
      if (r) break;
    end
    if (!r) fail_now("send_timeout");
  endtask

  typedef struct {
    logic [15:0] instr;
    dec_fields_t exp;
  } vec_t;

  vec_t vecs[5];
  int   n_before, span;
  logic [3:0] hold_op;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // cond, op, dest, src1, src2, shift, illegal
    vecs[0] = '{16'b01_0011_101_010_001_0, '{2'd1, 4'h3, 3'd5, 3'd2, 3'd1, 4'b0010, 1'b0}};
    vecs[1] = '{16'b11_1101_000_111_110_1, '{2'd3, 4'hD, 3'd0, 3'd7, 3'd6, 4'b1101, 1'b1}};
    vecs[2] = '{16'b00_0000_111_000_000_0, '{2'd0, 4'h0, 3'd7, 3'd0, 3'd0, 4'b0000, 1'b0}};
    vecs[3] = '{16'b10_1111_011_011_011_1, '{2'd2, 4'hF, 3'd3, 3'd3, 3'd3, 4'b0111, 1'b1}};
    vecs[4] = '{16'b01_1011_010_100_101_1, '{2'd1, 4'hB, 3'd2, 3'd4, 3'd5, 4'b1011, 1'b0}};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fields", 32'(actual()), 32'd0);
    chk("rst_raw_hazard", 32'(raw_hazard), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: single instruction, one-cycle latency, decoded fields against hand-computed constants.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].instr, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_fields", 32'(actual()), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // Back-to-back stream of eight.
    out_stamps.delete();
    for (int i = 0; i < 8; i++) send(16'(i * 16'h1357 + 16'h0420), 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    span = (out_stamps.size() == 8) ? out_stamps[7] - out_stamps[0] : -1;
    chk("stream_count", 32'(out_stamps.size()), 32'd8);
    chk("stream_consec", 32'(span), 32'd7);

    // Stall with three offered: two accepted, third waits, all drain in order.
    out_stamps.delete();
    out_ready = 1'b0;
    send(16'b10_0101_001_010_011_0, 1'b0);
    send(16'b01_0110_100_101_110_1, 1'b0);
    in_instr = 16'b11_0111_111_001_010_0;
    in_valid = 1'b1;
    hold_op  = 4'h5;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_op_hold", 32'(op_code), 32'(hold_op));
    end
    out_ready = 1'b1;
    send(16'b11_0111_111_001_010_0, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stall_drain_empty", 32'(sb.size()), 32'd0);
    chk("stall_out_count", 32'(out_stamps.size()), 32'd3);

    // Flush with both entries full and a word offered.
    out_ready = 1'b0;
    send(16'b00_0010_001_001_001_0, 1'b0);
    send(16'b00_0011_010_010_010_0, 1'b0);
    in_instr = 16'b00_0100_011_011_011_0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    n_before  = out_stamps.size();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_delivery", 32'(out_stamps.size()), 32'(n_before));

    // Flush in the same cycle as an accepted word discards it.
    in_instr = 16'b01_0001_110_110_110_0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_discard", 32'(out_valid), 32'd0);

    // Hazard: dest=3 followed by src1=3, then the same pair separated by a flush.
    send(16'b00_0001_011_000_000_0, 1'b0);
    send(16'b00_0001_000_011_000_0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("haz_set", 32'(raw_hazard), 32'(HAZ));
    @(posedge clk); #1;
    send(16'b00_0001_011_000_000_0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send(16'b00_0001_000_011_000_0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("haz_flushed", 32'(raw_hazard), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while stalled clears both entries immediately.
    out_ready = 1'b0;
    send(16'b10_0010_101_101_101_0, 1'b0);
    send(16'b10_0011_110_110_110_0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
